// File: rtl/mem_pkg.sv
// Shared definitions for the mem_bank data memory: FSM states, latency
// counter width and the legal parameter range helper.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Latency counter holds LATENCY-1, so 4 bits covers LATENCY up to 15.
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned LAT_MIN = 1;
    localparam int unsigned LAT_MAX = 15;

    // True when the latency fits the counter and the word splits into bytes.
    function automatic bit params_ok(int unsigned lat, int unsigned dw);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX) && (dw != 0) && ((dw % 8) == 0);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Storage for mem_bank: WORDS x DATA_WIDTH, synchronous read every cycle,
// per-byte write enables, no reset on contents or the read register.
// Ports:
//   clk      clock
//   rd_idx   read word index, sampled every rising edge
//   rd_data  registered read data
//   wr_idx   write word index
//   wr_be    per-byte write enables (all zero = no write)
//   wr_data  write data
module mem_array #(
    parameter int unsigned WORDS      = 4096,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IDX_W      = 12
) (
    input  logic                    clk,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [DATA_WIDTH-1:0]   rd_data,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]   wr_data
);

    localparam int unsigned NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [WORDS];

    // Read-before-write port; lanes written independently.
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_idx];
        for (int i = 0; i < int'(NB); i++) begin
            if (wr_be[i]) begin
                mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_bank.sv
// Single-port data memory with req/ready handshake, byte-lane writes,
// LATENCY wait cycles between accept and commit, and out-of-range detect.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   mem_req      request valid (accepted in IDLE)
//   rd_wr_bar    1 = read, 0 = write
//   address      word address
//   data_in      write data
//   byte_en      write lane enables, ignored on reads
//   req_ready    block can accept a request (IDLE)
//   resp_valid   one-cycle response strobe (RESP)
//   data_out     read data, updated only on read responses
//   addr_err     response address was >= WORDS
module mem_bank
    import mem_pkg::*;
#(
    parameter int unsigned WORDS      = 4096,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mem_req,
    input  logic                    rd_wr_bar,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    output logic                    req_ready,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    addr_err
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    // Compare in a width that holds both the full address and WORDS.
    localparam int unsigned CMP_W = ((ADDR_WIDTH > 32) ? ADDR_WIDTH : 32) + 1;

    if (!params_ok(LATENCY, DATA_WIDTH)) begin : g_bad_params
        $error("mem_bank: LATENCY must be 1..15 and DATA_WIDTH a multiple of 8");
    end

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    rd_q, rd_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]           be_q, be_d;
    logic [DATA_WIDTH-1:0]   data_out_d;
    logic                    addr_err_d;

    logic                    oor_c;
    logic [IDX_W-1:0]        rd_idx_c;
    logic [NB-1:0]           wr_be_c;
    logic [DATA_WIDTH-1:0]   rd_data;

    assign oor_c      = CMP_W'(addr_q) >= CMP_W'(WORDS);
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);

    // Array re-reads the captured word every WAIT cycle; in IDLE it reads the
    // incoming address so LATENCY = 1 already has data at the commit edge.
    mem_array #(
        .WORDS      (WORDS),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk     (clk),
        .rd_idx  (rd_idx_c),
        .rd_data (rd_data),
        .wr_idx  (IDX_W'(addr_q)),
        .wr_be   (wr_be_c),
        .wr_data (wdata_q)
    );

    // Next-state, capture and commit decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rd_d       = rd_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        data_out_d = data_out;
        addr_err_d = addr_err;
        wr_be_c    = '0;
        rd_idx_c   = IDX_W'(addr_q);

        case (state_q)
            IDLE: begin
                rd_idx_c = IDX_W'(address);
                if (mem_req) begin
                    addr_d  = address;
                    rd_d    = rd_wr_bar;
                    wdata_d = data_in;
                    be_d    = byte_en;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    addr_err_d = oor_c;
                    if (rd_q) begin
                        data_out_d = oor_c ? '0 : rd_data;
                    end else if (!oor_c) begin
                        wr_be_c = be_q;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, capture and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            wdata_q  <= '0;
            be_q     <= '0;
            data_out <= '0;
            addr_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            data_out <= data_out_d;
            addr_err <= addr_err_d;
        end
    end

endmodule

// File: tb/tb_mem_bank.sv
// Directed bench for mem_bank: LATENCY=2 instance for data paths, LATENCY=1
// instance for the back-to-back handshake pattern.
module tb_mem_bank;

    logic        clk;
    logic        rst_n;

    logic        mem_req, rd_wr_bar;
    logic [23:0] address;
    logic [31:0] data_in;
    logic [3:0]  byte_en;
    logic        req_ready, resp_valid, addr_err;
    logic [31:0] data_out;

    logic        mem_req1, rd_wr_bar1;
    logic [23:0] address1;
    logic [31:0] data_in1;
    logic [3:0]  byte_en1;
    logic        req_ready1, resp_valid1, addr_err1;
    logic [31:0] data_out1;

    int checks   = 0;
    int failures = 0;

    mem_bank #(.WORDS(4096), .DATA_WIDTH(32), .ADDR_WIDTH(24), .LATENCY(2)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_req    (mem_req),
        .rd_wr_bar  (rd_wr_bar),
        .address    (address),
        .data_in    (data_in),
        .byte_en    (byte_en),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .data_out   (data_out),
        .addr_err   (addr_err)
    );

    mem_bank #(.WORDS(4096), .DATA_WIDTH(32), .ADDR_WIDTH(24), .LATENCY(1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_req    (mem_req1),
        .rd_wr_bar  (rd_wr_bar1),
        .address    (address1),
        .data_in    (data_in1),
        .byte_en    (byte_en1),
        .req_ready  (req_ready1),
        .resp_valid (resp_valid1),
        .data_out   (data_out1),
        .addr_err   (addr_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transaction on the LATENCY=2 instance; starts and ends at a negedge.
    task automatic do_req(input string tag, input logic rd, input logic [23:0] a,
                          input logic [31:0] d, input logic [3:0] be,
                          output logic [31:0] dout, output logic err);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, 64'(req_ready), 64'(1));
        mem_req   = 1'b1;
        rd_wr_bar = rd;
        address   = a;
        data_in   = d;
        byte_en   = be;
        @(posedge clk);
        @(negedge clk);
        mem_req = 1'b0;
        data_in = 32'h0BAD_0BAD;
        byte_en = 4'hF;
        chk({tag, "_busy"}, 64'(req_ready), 64'(0));
        n = 1;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(3));
        dout = data_out;
        err  = addr_err;
    endtask

    logic [31:0] dv;
    logic        ev;
    int          resp_cnt;

    initial begin
        rst_n = 1'b0;
        mem_req = 1'b0; rd_wr_bar = 1'b1; address = '0; data_in = '0; byte_en = '0;
        mem_req1 = 1'b0; rd_wr_bar1 = 1'b1; address1 = '0; data_in1 = '0; byte_en1 = '0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_ready", 64'(req_ready), 64'(1));
        chk("rst_resp",  64'(resp_valid), 64'(0));
        chk("rst_dout",  64'(data_out), 64'(0));
        chk("rst_err",   64'(addr_err), 64'(0));
        chk("rst_ready1", 64'(req_ready1), 64'(1));
        rst_n = 1'b1;
        @(negedge clk);

        // Abort a write of 0xDEADBEEF to 5 mid-WAIT
        mem_req = 1'b1; rd_wr_bar = 1'b0; address = 24'd5; data_in = 32'hDEAD_BEEF; byte_en = 4'hF;
        @(posedge clk);
        @(negedge clk);
        mem_req = 1'b0;
        chk("abort_in_wait", 64'(req_ready), 64'(0));
        #1 rst_n = 1'b0;
        #1;
        chk("abort_ready", 64'(req_ready), 64'(1));
        chk("abort_resp",  64'(resp_valid), 64'(0));
        chk("abort_dout",  64'(data_out), 64'(0));
        chk("abort_err",   64'(addr_err), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_resp", 64'(resp_valid), 64'(0));
        end
        do_req("abort_rd", 1'b1, 24'd5, 32'h0, 4'h0, dv, ev);
        chk("abort_dropped", 64'(dv === 32'hDEAD_BEEF), 64'(0));

        // Basic write/read
        do_req("wr10", 1'b0, 24'h10, 32'h1234_5678, 4'hF, dv, ev);
        chk("wr10_err", 64'(ev), 64'(0));
        do_req("rd10", 1'b1, 24'h10, 32'h0, 4'h0, dv, ev);
        chk("rd10_data", 64'(dv), 64'h1234_5678);
        chk("rd10_err",  64'(ev), 64'(0));

        // Byte lanes
        do_req("bl_wr1", 1'b0, 24'h30, 32'hAABB_CCDD, 4'hF, dv, ev);
        do_req("bl_wr2", 1'b0, 24'h30, 32'h1122_3344, 4'b0101, dv, ev);
        do_req("bl_rd",  1'b1, 24'h30, 32'h0, 4'h0, dv, ev);
        chk("bl_data", 64'(dv), 64'hAA22_CC44);

        // byte_en = 0 is a no-op write that still responds
        do_req("be0_wr", 1'b0, 24'h30, 32'hFFFF_FFFF, 4'h0, dv, ev);
        do_req("be0_rd", 1'b1, 24'h30, 32'h0, 4'h0, dv, ev);
        chk("be0_data", 64'(dv), 64'hAA22_CC44);

        // Out of range: 0x1000 must not alias onto word 0
        do_req("or_w0",   1'b0, 24'h000, 32'h0102_0304, 4'hF, dv, ev);
        do_req("or_wfff", 1'b0, 24'hFFF, 32'hCAFE_F00D, 4'hF, dv, ev);
        do_req("or_w1k",  1'b0, 24'h1000, 32'h5A5A_5A5A, 4'hF, dv, ev);
        chk("or_w1k_err", 64'(ev), 64'(1));
        do_req("or_r1k",  1'b1, 24'h1000, 32'h0, 4'h0, dv, ev);
        chk("or_r1k_err",  64'(ev), 64'(1));
        chk("or_r1k_data", 64'(dv), 64'(0));
        do_req("or_rfff", 1'b1, 24'hFFF, 32'h0, 4'h0, dv, ev);
        chk("or_rfff_data", 64'(dv), 64'hCAFE_F00D);
        chk("or_rfff_err",  64'(ev), 64'(0));
        do_req("or_r0", 1'b1, 24'h000, 32'h0, 4'h0, dv, ev);
        chk("or_r0_data", 64'(dv), 64'h0102_0304);
        do_req("or_top", 1'b1, 24'hFF_FFFF, 32'h0, 4'h0, dv, ev);
        chk("or_top_err", 64'(ev), 64'(1));

        // data_out holds across a write response
        do_req("hold_w20", 1'b0, 24'h20, 32'h0000_0055, 4'hF, dv, ev);
        do_req("hold_r20", 1'b1, 24'h20, 32'h0, 4'h0, dv, ev);
        chk("hold_r20_data", 64'(dv), 64'h55);
        do_req("hold_w21", 1'b0, 24'h21, 32'h0000_0099, 4'hF, dv, ev);
        chk("hold_wresp", 64'(dv), 64'h55);
        @(negedge clk);
        chk("hold_after", 64'(data_out), 64'h55);

        // Handshake on LATENCY=1: mem_req held high, accept every 3 cycles
        mem_req1 = 1'b1; rd_wr_bar1 = 1'b1; address1 = 24'h0;
        resp_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            chk("hs_ready", 64'(req_ready1),  64'((i % 3) == 0));
            chk("hs_resp",  64'(resp_valid1), 64'((i % 3) == 2));
            if (resp_valid1) resp_cnt++;
            @(negedge clk);
        end
        mem_req1 = 1'b0;
        chk("hs_resp_count", 64'(resp_cnt), 64'(3));
        repeat (3) begin
            @(negedge clk);
            chk("hs_quiet", 64'(resp_valid1), 64'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_bank.md
# mem_bank

Parametrised single-port data memory with a request/ready handshake, byte-lane write enables, a configurable access latency (wait states) and out-of-range address detection. It generalises the existing flat memory model, which has fixed 32-bit width, a combinational read and no handshake, into a block the core's load/store unit can drive directly. It sits between the LSU and on-chip storage: one outstanding request at a time, and every request gets exactly one response.

## Interface
Parameters:
- WORDS, 4096: number of storage words.
- DATA_WIDTH, 32: word width. Must be a multiple of 8.
- ADDR_WIDTH, 24: word-address width.
- LATENCY, 2: wait cycles from accept to memory commit. Legal values are 1 to 15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_req  in  1  request valid.
- rd_wr_bar  in  1  1 = read, 0 = write.
- address  in  ADDR_WIDTH  word address.
- data_in  in  DATA_WIDTH  write data.
- byte_en  in  DATA_WIDTH/8  write lane enables; bit i covers byte i. Ignored on reads.
- req_ready  out  1  block can accept a request.
- resp_valid  out  1  one-cycle response strobe.
- data_out  out  DATA_WIDTH  read data, qualified by resp_valid on a read.
- addr_err  out  1  response was for an address ≥ WORDS; qualified by resp_valid.

## Operation
- The FSM has three states: IDLE, WAIT, RESP.
- **IDLE**
  - req_ready = 1 (combinational decode of state).
  - If mem_req = 1 at an edge, the request is accepted. address, rd_wr_bar, data_in and byte_en are captured, cnt ← LATENCY−1, and the FSM goes to WAIT.
- **WAIT**
  - req_ready = 0. Inputs are ignored.
  - At each edge where cnt ≠ 0: cnt ← cnt−1.
  - At the edge where cnt = 0, the access is performed:
    - Read, in range: data_out ← mem[addr].
    - Write, in range: only lanes with byte_en[i] = 1 are updated. byte_en = 0 is a legal no-op that still gets a response.
    - Out of range: nothing is written; a read returns data_out ← 0.
    - In all cases addr_err ← (addr ≥ WORDS), and the FSM goes to RESP.
- **RESP**
  - resp_valid = 1 for exactly one cycle. There is no response backpressure.
  - The next edge returns the FSM to IDLE.
- data_out changes only on read responses and holds its value otherwise, including across write responses.
- The address comparison uses the full ADDR_WIDTH. It must be correct when WORDS is not a power of 2 and when 2^ADDR_WIDTH < WORDS.
- Storage contents are not reset. Reading a never-written word returns X in simulation.

## Timing
- Accept edge = E0. The memory commit happens at edge E0+LATENCY. resp_valid is high in the cycle between E0+LATENCY and E0+LATENCY+1.
- req_ready rises after edge E0+LATENCY+1. A new request can be accepted at edge E0+LATENCY+2 at the earliest.
- Peak throughput is one request per LATENCY+2 cycles.
- Read-after-write to the same word returns the new data, because the previous write commits before the next accept.
- mem_req held high while req_ready = 0 is not an error. The request is accepted at the first edge back in IDLE.
- Reset values: FSM = IDLE, req_ready = 1, resp_valid = 0, data_out = 0, addr_err = 0, cnt = 0.
- Reset asserted mid-operation aborts the access. A write not yet committed is dropped, and no response is issued for the aborted request.

## Structure
- Package mem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - the latency counter width, 4 bits;
  - the legal LATENCY range, checked with an elaboration-time assertion together with DATA_WIDTH % 8 == 0.
- One sub-module, mem_array, holds the storage: WORDS × DATA_WIDTH, synchronous read, per-byte write enable, no reset.
- mem_bank holds the FSM, the request capture registers, the range check and the output registers.

## Test plan
- **Reset:** assert rst_n = 0 mid-WAIT of a write of 0xDEADBEEF to address 5 → outputs return to reset values immediately. A later read of address 5 does not return 0xDEADBEEF.
- **Basic write/read, LATENCY = 2:** write 0x12345678 to address 0x10 with byte_en = 4'hF, then read 0x10 → resp_valid 2 cycles after each accept, data_out = 0x12345678, addr_err = 0.
- **Byte lanes:** write 0xAABBCCDD with byte_en = 4'hF, then 0x11223344 with byte_en = 4'b0101, then read → 0xAA22CC44.
- **Out of range, WORDS = 4096:** write to address 0x1000, then read 0x1000 → both responses have addr_err = 1, and the read gives data_out = 0. A read of address 0x0FFF still returns its prior contents.
- **Handshake:** hold mem_req high continuously with LATENCY = 1 → an accept every 3 cycles, exactly one resp_valid per accept, req_ready low in WAIT and RESP.
- **Data_out hold:** read 0x20 (value 0x55), then write 0x21 → data_out stays 0x55 through the write response.
